// File: rtl/player_ctrl_if.sv
// ============================================================================
//  Module   : player_ctrl_if
//  Purpose  : Button/transport bundle between a control source and player_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface player_ctrl_if #(
    parameter int SEL_W     = 2,
    parameter int ELAPSED_W = 10
);
    logic                 start;
    logic                 stop;
    logic                 next;
    logic                 prev;
    logic                 tick;
    logic                 song_done;
    logic [1:0]           mode;

    logic                 play_enable;
    logic [SEL_W-1:0]     sel_song;
    logic                 song_restart;
    logic                 play_tick;
    logic [ELAPSED_W-1:0] elapsed;

    modport master (
        output start, stop, next, prev, tick, song_done, mode,
        input  play_enable, sel_song, song_restart, play_tick, elapsed
    );

    modport slave (
        input  start, stop, next, prev, tick, song_done, mode,
        output play_enable, sel_song, song_restart, play_tick, elapsed
    );
endinterface

`default_nettype wire

// File: rtl/player_ctrl.sv
// ============================================================================
//  Module   : player_ctrl
//  Purpose  : Play/pause/idle transport control and song selection for the
//             tone player, with gated note tick and elapsed-tick counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module player_ctrl #(
    parameter int NUM_SONGS = 3,
    parameter int SEL_W     = 2,
    parameter int ELAPSED_W = 10
) (
    input  wire logic      clk,
    input  wire logic      reset,
    player_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0]       c_MODE_SINGLE     = 2'd0;
    localparam logic [1:0]       c_MODE_REPEAT_ONE = 2'd1;
    localparam logic [1:0]       c_MODE_SEQUENTIAL = 2'd2;
    localparam logic [1:0]       c_MODE_LOOP_ALL   = 2'd3;
    localparam logic [SEL_W-1:0] c_LAST_SONG       = SEL_W'(NUM_SONGS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_start_q;
    logic                  r_stop_q;
    logic                  r_next_q;
    logic                  r_prev_q;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic                  r_restart;
    logic                  w_restart_nxt;
    logic                  r_play_tick;
    logic                  w_play_tick_nxt;
    logic [ELAPSED_W-1:0]  r_elapsed;
    logic [ELAPSED_W-1:0]  w_elapsed_nxt;

    logic                  w_rise_start;
    logic                  w_rise_stop;
    logic                  w_rise_next;
    logic                  w_rise_prev;
    logic [SEL_W-1:0]      w_sel_inc;
    logic [SEL_W-1:0]      w_sel_dec;

    assign w_rise_start = bus.start & ~r_start_q;
    assign w_rise_stop  = bus.stop  & ~r_stop_q;
    assign w_rise_next  = bus.next  & ~r_next_q;
    assign w_rise_prev  = bus.prev  & ~r_prev_q;

    assign w_sel_inc = (r_sel == c_LAST_SONG) ? '0 : r_sel + SEL_W'(1);
    assign w_sel_dec = (r_sel == '0) ? c_LAST_SONG : r_sel - SEL_W'(1);

    // History regs reset high so a button held through reset release is not an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_q <= 1'b1;
            r_stop_q  <= 1'b1;
            r_next_q  <= 1'b1;
            r_prev_q  <= 1'b1;
        end else begin
            r_start_q <= bus.start;
            r_stop_q  <= bus.stop;
            r_next_q  <= bus.next;
            r_prev_q  <= bus.prev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_restart   <= 1'b0;
            r_play_tick <= 1'b0;
            r_elapsed   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_restart   <= w_restart_nxt;
            r_play_tick <= w_play_tick_nxt;
            r_elapsed   <= w_elapsed_nxt;
        end
    end

    // Only the highest-priority event acts; a simultaneous next+prev consumes the slot as a no-op.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_restart_nxt = 1'b0;

        if (w_rise_stop) begin
            w_state_nxt   = ST_IDLE;
            w_restart_nxt = 1'b1;
        end else if (w_rise_start) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt   = ST_PLAY;
                    w_restart_nxt = 1'b1;
                end
                ST_PLAY:  w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_PLAY;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end else if (w_rise_next || w_rise_prev) begin
            if (w_rise_next && !w_rise_prev) begin
                w_sel_nxt     = w_sel_inc;
                w_restart_nxt = 1'b1;
            end else if (w_rise_prev && !w_rise_next) begin
                w_sel_nxt     = w_sel_dec;
                w_restart_nxt = 1'b1;
            end
        end else if (bus.song_done && (r_state == ST_PLAY)) begin
            w_restart_nxt = 1'b1;
            case (bus.mode)
                c_MODE_SINGLE:     w_state_nxt = ST_IDLE;
                c_MODE_REPEAT_ONE: w_state_nxt = ST_PLAY;
                c_MODE_SEQUENTIAL: begin
                    if (r_sel == c_LAST_SONG) begin
                        w_state_nxt = ST_IDLE;
                        w_sel_nxt   = '0;
                    end else begin
                        w_sel_nxt   = w_sel_inc;
                    end
                end
                c_MODE_LOOP_ALL:   w_sel_nxt = w_sel_inc;
                default:           w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // A tick counts only if we are playing now and remain playing after this edge.
    always_comb begin
        w_play_tick_nxt = bus.tick && (r_state == ST_PLAY) && (w_state_nxt == ST_PLAY);
        w_elapsed_nxt   = r_elapsed;
        if (w_restart_nxt) begin
            w_elapsed_nxt = '0;
        end else if (w_play_tick_nxt && !(&r_elapsed)) begin
            w_elapsed_nxt = r_elapsed + ELAPSED_W'(1);
        end
    end

    assign bus.play_enable  = (r_state == ST_PLAY);
    assign bus.sel_song     = r_sel;
    assign bus.song_restart = r_restart;
    assign bus.play_tick    = r_play_tick;
    assign bus.elapsed      = r_elapsed;

endmodule

`default_nettype wire

// File: tb/tb_player_ctrl.sv
// ============================================================================
//  Module   : tb_player_ctrl
//  Purpose  : Directed + random stimulus with reference model and scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_player_ctrl;
    localparam int NS = 3;
    localparam int SW = 2;
    localparam int EW = 4;

    localparam bit [6:0] B_RST   = 7'h40;
    localparam bit [6:0] B_START = 7'h20;
    localparam bit [6:0] B_STOP  = 7'h10;
    localparam bit [6:0] B_NEXT  = 7'h08;
    localparam bit [6:0] B_PREV  = 7'h04;
    localparam bit [6:0] B_TICK  = 7'h02;
    localparam bit [6:0] B_DONE  = 7'h01;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    player_ctrl_if #(.SEL_W(SW), .ELAPSED_W(EW)) bus();

    player_ctrl #(.NUM_SONGS(NS), .SEL_W(SW), .ELAPSED_W(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic          pe;
        logic [SW-1:0] sel;
        logic          rs;
        logic          pt;
        logic [EW-1:0] el;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 idle, 1 playing, 2 paused
    int m_mode_state = 0;
    int m_song       = 0;
    int m_count      = 0;
    bit h_start = 1, h_stop = 1, h_next = 1, h_prev = 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit [6:0] v, input logic [1:0] md);
        exp_t e;
        bit   rs_start, rs_stop, rs_next, rs_prev, restart, counted;
        int   nstate, nsong;
        @(negedge clk);
        reset         = v[6];
        bus.start     = v[5];
        bus.stop      = v[4];
        bus.next      = v[3];
        bus.prev      = v[2];
        bus.tick      = v[1];
        bus.song_done = v[0];
        bus.mode      = md;
        restart = 0;
        counted = 0;
        if (v[6]) begin
            m_mode_state = 0; m_song = 0; m_count = 0;
            h_start = 1; h_stop = 1; h_next = 1; h_prev = 1;
        end else begin
            rs_start = v[5] && !h_start;
            rs_stop  = v[4] && !h_stop;
            rs_next  = v[3] && !h_next;
            rs_prev  = v[2] && !h_prev;
            h_start = v[5]; h_stop = v[4]; h_next = v[3]; h_prev = v[2];
            nstate = m_mode_state;
            nsong  = m_song;
            if (rs_stop) begin
                nstate = 0; restart = 1;
            end else if (rs_start) begin
                if (m_mode_state == 0) begin nstate = 1; restart = 1; end
                else if (m_mode_state == 1) nstate = 2;
                else nstate = 1;
            end else if (rs_next || rs_prev) begin
                if (rs_next != rs_prev) begin
                    nsong   = rs_next ? (m_song + 1) % NS : (m_song + NS - 1) % NS;
                    restart = 1;
                end
            end else if (v[0] && m_mode_state == 1) begin
                restart = 1;
                case (md)
                    2'd0: nstate = 0;
                    2'd1: ;
                    2'd2: if (m_song == NS - 1) begin nstate = 0; nsong = 0; end
                          else nsong = m_song + 1;
                    default: nsong = (m_song + 1) % NS;
                endcase
            end
            counted = v[1] && m_mode_state == 1 && nstate == 1;
            if (restart) m_count = 0;
            else if (counted && m_count < (1 << EW) - 1) m_count++;
            m_mode_state = nstate;
            m_song       = nsong;
        end
        e.pe  = (m_mode_state == 1);
        e.sel = SW'(m_song);
        e.rs  = restart;
        e.pt  = counted;
        e.el  = EW'(m_count);
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("play_enable",  16'(bus.play_enable),  16'(e.pe));
                chk("sel_song",     16'(bus.sel_song),     16'(e.sel));
                chk("song_restart", 16'(bus.song_restart), 16'(e.rs));
                chk("play_tick",    16'(bus.play_tick),    16'(e.pt));
                chk("elapsed",      16'(bus.elapsed),      16'(e.el));
            end
        end
    end

    initial begin : driver
        bit [6:0]   lv;
        logic [1:0] md;
        bus.start = 0; bus.stop = 0; bus.next = 0; bus.prev = 0;
        bus.tick = 0; bus.song_done = 0; bus.mode = 2'd0;

        cyc(B_RST | B_START, 0); cyc(B_RST | B_START, 0);
        cyc(B_START, 0); cyc(B_START, 0); cyc(0, 0);
        cyc(B_START, 0); cyc(0, 0);
        repeat (5) begin cyc(B_TICK, 0); cyc(0, 0); end
        cyc(B_START, 0); cyc(0, 0);
        repeat (3) cyc(B_TICK, 0);
        cyc(B_START, 0); cyc(0, 0);
        repeat (2) begin cyc(B_TICK, 0); cyc(0, 0); end
        cyc(B_PREV, 0); cyc(0, 0);
        repeat (3) begin cyc(B_NEXT, 0); cyc(0, 0); end
        cyc(B_NEXT | B_PREV, 0); cyc(0, 0);
        cyc(B_DONE, 2); cyc(0, 2);
        cyc(B_START, 3); cyc(0, 3); cyc(B_PREV, 3); cyc(0, 3);
        cyc(B_DONE, 3); cyc(0, 1);
        cyc(B_DONE, 1); cyc(0, 0);
        cyc(B_DONE, 0); cyc(0, 0);
        cyc(B_START, 0); cyc(0, 0);
        cyc(B_STOP | B_START, 0); cyc(0, 0);
        cyc(B_START, 0); cyc(0, 0);
        cyc(B_STOP | B_DONE, 0); cyc(0, 0);
        cyc(B_START, 3); cyc(0, 3);
        cyc(B_NEXT | B_DONE, 3); cyc(0, 3);
        repeat (20) cyc(B_TICK, 3);
        cyc(B_RST | B_TICK, 3); cyc(0, 3);

        lv = 0;
        md = 2'd0;
        repeat (3000) begin
            for (int b = 2; b <= 5; b++)
                if ($urandom_range(5) == 0) lv[b] = ~lv[b];
            lv[1] = ($urandom_range(2) == 0);
            lv[0] = ($urandom_range(7) == 0);
            lv[6] = ($urandom_range(99) == 0);
            if ($urandom_range(49) == 0) md = 2'($urandom_range(3));
            cyc(lv, md);
        end
        cyc(0, md);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Playback controller for the tone-player datapath. Parametrised over song count.
- Turns debounced start/stop/next/prev button levels into a play/pause/idle state machine and a song-select index.
- Produces a gated note tick, a restart pulse and an elapsed-tick counter for the play engine and the display.
- Adds pause/resume, previous-song, and four end-of-song modes. All logic is synchronous: no button-clocked registers.

Parameters:
- NUM_SONGS, 3, number of selectable songs (>=2, <=2**SEL_W)
- SEL_W, 2, width of sel_song
- ELAPSED_W, 10, width of elapsed tick counter

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  debounced level; rising edge = play/pause toggle
- stop  input  1  debounced level; rising edge = full stop
- next  input  1  debounced level; rising edge = next song
- prev  input  1  debounced level; rising edge = previous song
- tick  input  1  one-clk-wide note-rate enable (4 Hz)
- song_done  input  1  one-clk pulse from play engine at end of score
- mode  input  2  0 SINGLE, 1 REPEAT_ONE, 2 SEQUENTIAL, 3 LOOP_ALL
- play_enable  output  1  high in PLAY state
- sel_song  output  SEL_W  current song index
- song_restart  output  1  one-clk pulse: play engine rewinds to note 0
- play_tick  output  1  tick gated by PLAY, registered
- elapsed  output  ELAPSED_W  ticks played in current song

Behaviour:
- Reset: state IDLE; sel_song 0; play_enable 0; song_restart 0; play_tick 0; elapsed 0.
- Reset loads the four edge-history regs with 1, so a button held through reset release produces no event.
- Edge detect: rise_x = x & ~x_q, with x_q registered each clk.
- Effects of a rise appear on the same clk edge that first samples x high, so outputs are valid the next cycle. Holding a button gives exactly one event.
- States: IDLE, PLAY, PAUSE. play_enable = (state==PLAY), registered.
- Event priority per cycle, highest first: stop > start > next/prev > song_done. Only the highest-priority event acts; lower ones are dropped.
- stop: any state -> IDLE; song_restart=1; elapsed=0; sel_song unchanged.
- start:
  - IDLE -> PLAY with song_restart=1 and elapsed=0.
  - PLAY -> PAUSE, keeping position and elapsed.
  - PAUSE -> PLAY (resume) with no restart.
- next: sel_song = (sel==NUM_SONGS-1) ? 0 : sel+1.
- prev: sel_song = (sel==0) ? NUM_SONGS-1 : sel-1.
- next/prev common rules:
  - Both also give song_restart=1 and elapsed=0; state unchanged.
  - rise_next & rise_prev in the same cycle: no change, no pulse.
- song_done: acted on only in PLAY; ignored in IDLE and PAUSE.
  - SINGLE: -> IDLE, sel unchanged.
  - REPEAT_ONE: stay PLAY, sel unchanged.
  - SEQUENTIAL: if sel==NUM_SONGS-1 -> IDLE, sel=0; else sel+1, stay PLAY.
  - LOOP_ALL: sel wraps as next, stay PLAY.
  - Every case also gives song_restart=1 and elapsed=0.
- play_tick = registered (tick & state==PLAY): 1-cycle latency. It is 0 in the cycle after a transition out of PLAY.
- elapsed:
  - +1 on each tick while in PLAY; saturates at all-ones.
  - A restart in the same cycle as a tick clears it (clear wins).
- song_restart is never high two consecutive cycles unless two separate events occur in consecutive cycles.
- reset asserted mid-play overrides every event that cycle.

Test Plan:
- Reset, pulse start -> next cycle play_enable=1, song_restart=1 for 1 cycle, sel_song=0. Apply 5 ticks -> elapsed=5, five play_tick pulses, each 1 clk after tick.
- In PLAY press start -> PAUSE, play_enable=0, elapsed holds 5. Ticks give no play_tick. Press start again -> PLAY, no song_restart, elapsed continues from 5.
- NUM_SONGS=3, sel=0: prev -> sel=2; next three times -> 0,1,2. Each gives one song_restart. Next and prev in the same cycle -> sel unchanged, no pulse.
- mode=2, sel=2, PLAY, song_done -> IDLE, sel=0. mode=3, sel=2 -> sel=0, still PLAY. mode=1 -> sel unchanged, PLAY, restart. mode=0 -> IDLE.
- Same-cycle stop+start, and stop+song_done -> IDLE, one song_restart. next+song_done (mode=3, sel=0) -> sel=1 only.
- Hold start high through reset release -> no PLAY. ELAPSED_W=4 with 20 ticks -> elapsed saturates at 15. Reset during PLAY -> all outputs return to reset values next cycle.
